// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dm_pkg
// Brief    : Shared size codes, port indices and access check for dm_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dm_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } dm_size_e;

    localparam int P_CPU = 0;
    localparam int P_DBG = 1;

    // True when an access of this size at this address must not reach memory.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_WORD: bad = (addr_lo != 2'b00);
            SZ_HALF: bad = addr_lo[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin grant with a registered priority pointer.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 #(
    parameter bit PTR_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 1 = port 0 wins a conflict, 0 = port 1 wins.
    logic r_p0_prio;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = r_p0_prio ? 2'b01 : 2'b10;
        end
    end

    // After a grant, priority passes to the port that was not served.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p0_prio <= PTR_RESET;
        end else if (advance) begin
            r_p0_prio <= gnt[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_arbiter
// Brief    : Round-robin sharing of the data memory between CPU and debug ports.
// Revision : 1.0 - initial release
// ============================================================================
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int unsigned AW            = 9,
    parameter bit          P0_PRIO_RESET = 1'b1,
    parameter bit          BYPASS_ERR    = 1'b0
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [1:0]    m0_byte,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    output logic          m0_err,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [1:0]    m1_byte,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          m1_err,

    output logic          dm_we,
    output logic [1:0]    dm_byte,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_din,
    input  logic [31:0]   dm_dout
);

    logic [1:0]    w_req;
    logic [1:0]    w_gnt;
    logic          w_any;
    logic          w_we;
    logic [1:0]    w_byte;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_wdata;
    logic          w_err;
    logic          w_rd_ok;

    logic [1:0]    r_hold_byte;
    logic [AW-1:0] r_hold_addr;
    logic [31:0]   r_hold_din;
    logic          r_rvalid [2];
    logic          r_err    [2];
    logic [31:0]   r_rdata  [2];

    // Nothing is granted while reset is held so no write can slip through.
    assign w_req = {m1_req, m0_req} & {2{~rst}};

    rr_arb2 #(
        .PTR_RESET (P0_PRIO_RESET)
    ) u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .advance (w_any),
        .gnt     (w_gnt)
    );

    assign w_any   = |w_gnt;
    assign w_we    = w_gnt[P_DBG] ? m1_we    : m0_we;
    assign w_byte  = w_gnt[P_DBG] ? m1_byte  : m0_byte;
    assign w_addr  = w_gnt[P_DBG] ? m1_addr  : m0_addr;
    assign w_wdata = w_gnt[P_DBG] ? m1_wdata : m0_wdata;
    assign w_err   = !BYPASS_ERR && access_err(w_byte, w_addr[1:0]);
    assign w_rd_ok = w_any && !w_we && !w_err;

    assign m0_gnt  = w_gnt[P_CPU];
    assign m1_gnt  = w_gnt[P_DBG];

    // Memory bus follows the winner and otherwise parks on the last access.
    assign dm_we   = w_any && w_we && !w_err;
    assign dm_byte = w_any ? w_byte  : r_hold_byte;
    assign dm_addr = w_any ? w_addr  : r_hold_addr;
    assign dm_din  = w_any ? w_wdata : r_hold_din;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_byte <= 2'b00;
            r_hold_addr <= '0;
            r_hold_din  <= 32'd0;
        end else if (w_any) begin
            r_hold_byte <= w_byte;
            r_hold_addr <= w_addr;
            r_hold_din  <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                r_rvalid[p] <= 1'b0;
                r_err[p]    <= 1'b0;
                r_rdata[p]  <= 32'd0;
            end else begin
                r_rvalid[p] <= w_gnt[p] && w_rd_ok;
                r_err[p]    <= w_gnt[p] && w_err;
                if (w_gnt[p] && w_rd_ok) begin
                    r_rdata[p] <= dm_dout;
                end
            end
        end
    end

    assign m0_rvalid = r_rvalid[P_CPU];
    assign m0_err    = r_err[P_CPU];
    assign m0_rdata  = r_rdata[P_CPU];
    assign m1_rvalid = r_rvalid[P_DBG];
    assign m1_err    = r_err[P_DBG];
    assign m1_rdata  = r_rdata[P_DBG];

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_arbiter
// Brief    : Directed bench for dm_arbiter with a byte-array memory and model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_mem;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [1:0]  m0_byte, m1_byte;
    logic [8:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        dm_we;
    logic [1:0]  dm_byte;
    logic [8:0]  dm_addr;
    logic [31:0] dm_din, dm_dout;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dm_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_byte(m0_byte), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_byte(m1_byte), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .dm_we(dm_we), .dm_byte(dm_byte), .dm_addr(dm_addr), .dm_din(dm_din),
        .dm_dout(dm_dout)
    );

    // Little-endian byte memory standing in for dm; reads are zero-extended.
    logic [7:0] mem [0:511];
    logic [8:0] a1, a2, a3;
    assign a1 = dm_addr + 9'd1;
    assign a2 = dm_addr + 9'd2;
    assign a3 = dm_addr + 9'd3;

    always_comb begin
        case (dm_byte)
            2'b00:   dm_dout = {mem[a3], mem[a2], mem[a1], mem[dm_addr]};
            2'b01:   dm_dout = {16'd0, mem[a1], mem[dm_addr]};
            default: dm_dout = {24'd0, mem[dm_addr]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'(i) ^ 8'hA5;
        end else if (dm_we) begin
            mem[dm_addr] <= dm_din[7:0];
            if (dm_byte != 2'b10) mem[a1] <= dm_din[15:8];
            if (dm_byte == 2'b00) begin
                mem[a2] <= dm_din[23:16];
                mem[a3] <= dm_din[31:24];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mdl [0:511];

    function automatic logic [31:0] mdl_rd(input int a, input int sz);
        logic [31:0] v = 32'd0;
        int n = (sz == 0) ? 4 : (sz == 1) ? 2 : 1;
        for (int k = 0; k < n; k++) v = v | (32'(mdl[(a + k) % 512]) << (8 * k));
        return v;
    endfunction

    initial begin : model
        logic        exp_rv [2];
        logic        exp_er [2];
        logic [31:0] exp_rd [2];
        logic        bad, we;
        logic [1:0]  sz;
        logic [8:0]  ad, last_addr;
        logic [1:0]  last_byte;
        logic [31:0] wd, last_din;
        int          win, prio, n;
        for (int i = 0; i < 512; i++) mdl[i] = 8'(i) ^ 8'hA5;
        prio = 0; last_addr = '0; last_byte = '0; last_din = '0;
        exp_rv = '{1'b0, 1'b0}; exp_er = '{1'b0, 1'b0}; exp_rd = '{32'd0, 32'd0};
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_rv = '{1'b0, 1'b0}; exp_er = '{1'b0, 1'b0}; exp_rd = '{32'd0, 32'd0};
                prio = 0; last_addr = '0; last_byte = '0; last_din = '0;
            end else begin
                chk("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv[0]));
                chk("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv[1]));
                chk("m0_err", 32'(m0_err), 32'(exp_er[0]));
                chk("m1_err", 32'(m1_err), 32'(exp_er[1]));
                chk("m0_rdata", m0_rdata, exp_rd[0]);
                chk("m1_rdata", m1_rdata, exp_rd[1]);
                win = -1;
                if (m0_req && m1_req) win = prio;
                else if (m0_req)      win = 0;
                else if (m1_req)      win = 1;
                chk("m0_gnt", 32'(m0_gnt), 32'(win == 0));
                chk("m1_gnt", 32'(m1_gnt), 32'(win == 1));
                we = (win == 1) ? m1_we : m0_we;
                sz = (win == 1) ? m1_byte : m0_byte;
                ad = (win == 1) ? m1_addr : m0_addr;
                wd = (win == 1) ? m1_wdata : m0_wdata;
                bad = (sz == 2'b11) || (sz == 2'b00 && (ad % 4) != 0) ||
                      (sz == 2'b01 && (ad % 2) != 0);
                if (win >= 0) begin
                    last_addr = ad; last_byte = sz; last_din = wd;
                end
                chk("dm_we", 32'(dm_we), 32'(win >= 0 && we && !bad));
                chk("dm_addr", 32'(dm_addr), 32'(last_addr));
                chk("dm_byte", 32'(dm_byte), 32'(last_byte));
                chk("dm_din", dm_din, last_din);
                exp_rv = '{1'b0, 1'b0}; exp_er = '{1'b0, 1'b0};
                if (win >= 0) begin
                    prio = 1 - win;
                    exp_er[win] = bad;
                    if (!we && !bad) begin
                        exp_rv[win] = 1'b1;
                        exp_rd[win] = mdl_rd(int'(ad), int'(sz));
                    end
                    if (we && !bad) begin
                        n = (sz == 0) ? 4 : (sz == 1) ? 2 : 1;
                        for (int k = 0; k < n; k++) mdl[(int'(ad) + k) % 512] = wd[8*k +: 8];
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int p, input logic req, input logic we, input logic [1:0] sz,
                       input logic [8:0] ad, input logic [31:0] wd);
        if (p == 0) begin
            m0_req = req; m0_we = we; m0_byte = sz; m0_addr = ad; m0_wdata = wd;
        end else begin
            m1_req = req; m1_we = we; m1_byte = sz; m1_addr = ad; m1_wdata = wd;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        drv(0, 0, 0, 2'b00, 9'h0, 32'h0);
        drv(1, 0, 0, 2'b00, 9'h0, 32'h0);
        init_mem = 1'b1;
        do_reset();
        init_mem = 1'b0;
        chk("reset m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("reset m1_err", 32'(m1_err), 32'd0);
        chk("reset m0_rdata", m0_rdata, 32'd0);
        chk("reset dm_addr", 32'(dm_addr), 32'd0);

        // 1: write then read back on port 0
        drv(0, 1, 1, 2'b00, 9'h010, 32'hDEADBEEF); #2;
        chk("t1 write gnt", 32'(m0_gnt), 32'd1);
        step();
        drv(0, 1, 0, 2'b00, 9'h010, 32'h0); #2;
        chk("t1 read gnt", 32'(m0_gnt), 32'd1);
        step();
        drv(0, 0, 0, 2'b00, 9'h0, 32'h0);
        chk("t1 rvalid", 32'(m0_rvalid), 32'd1);
        chk("t1 rdata", m0_rdata, 32'hDEADBEEF);
        step();

        // 2: continuous contention alternates starting with port 0
        do_reset();
        drv(0, 1, 0, 2'b00, 9'h020, 32'h0);
        drv(1, 1, 0, 2'b00, 9'h024, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #2;
            chk("t2 m0_gnt seq", 32'(m0_gnt), 32'(i % 2 == 0));
            chk("t2 m1_gnt seq", 32'(m1_gnt), 32'(i % 2 == 1));
            step();
        end
        drv(0, 0, 0, 2'b00, 9'h0, 32'h0);
        drv(1, 0, 0, 2'b00, 9'h0, 32'h0);
        step();

        // 3: back-to-back reads on port 1 alone
        drv(1, 1, 0, 2'b00, 9'h004, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t3 m1_gnt", 32'(m1_gnt), 32'd1);
            step();
            chk("t3 m1_rvalid", 32'(m1_rvalid), 32'd1);
            chk("t3 m1_rdata", m1_rdata, 32'hA2A3A0A1);
        end
        drv(1, 0, 0, 2'b00, 9'h0, 32'h0);
        step();

        // 4: misaligned word write and reserved size are rejected
        drv(0, 1, 1, 2'b00, 9'h006, 32'h12345678); #2;
        chk("t4 gnt", 32'(m0_gnt), 32'd1);
        chk("t4 dm_we", 32'(dm_we), 32'd0);
        step();
        drv(0, 0, 0, 2'b00, 9'h0, 32'h0);
        chk("t4 err", 32'(m0_err), 32'd1);
        chk("t4 no rvalid", 32'(m0_rvalid), 32'd0);
        step();
        drv(0, 1, 0, 2'b00, 9'h004, 32'h0);
        step();
        drv(0, 0, 0, 2'b00, 9'h0, 32'h0);
        chk("t4 unchanged", m0_rdata, 32'hA2A3A0A1);
        drv(0, 1, 1, 2'b11, 9'h000, 32'hFFFFFFFF); #2;
        chk("t4 rsvd dm_we", 32'(dm_we), 32'd0);
        step();
        drv(0, 1, 0, 2'b10, 9'h000, 32'h0);
        chk("t4 rsvd err", 32'(m0_err), 32'd1);
        chk("t4 rsvd rdata held", m0_rdata, 32'hA2A3A0A1);
        step();
        drv(0, 0, 0, 2'b00, 9'h0, 32'h0);
        chk("t4 byte0 intact", m0_rdata, 32'h000000A5);
        step();

        // 5: reset cancels a pending response and reloads the pointer
        drv(1, 1, 0, 2'b00, 9'h008, 32'h0); #2;
        chk("t5 m1_gnt", 32'(m1_gnt), 32'd1);
        step();
        drv(1, 0, 0, 2'b00, 9'h0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5 m1_rvalid cleared", 32'(m1_rvalid), 32'd0);
        chk("t5 m1_err cleared", 32'(m1_err), 32'd0);
        chk("t5 m1_rdata cleared", m1_rdata, 32'd0);
        drv(0, 1, 0, 2'b00, 9'h00C, 32'h0);
        drv(1, 1, 0, 2'b00, 9'h010, 32'h0); #2;
        chk("t5 port0 first", 32'(m0_gnt), 32'd1);
        chk("t5 port1 waits", 32'(m1_gnt), 32'd0);
        step();
        drv(0, 0, 0, 2'b00, 9'h0, 32'h0);
        drv(1, 0, 0, 2'b00, 9'h0, 32'h0);
        step();

        // 6: port 1 writes a halfword while port 0 reads the upper byte of it
        drv(1, 1, 1, 2'b01, 9'h002, 32'h0000ABCD);
        drv(0, 1, 0, 2'b10, 9'h003, 32'h0); #2;
        chk("t6 m1 first", 32'(m1_gnt), 32'd1);
        chk("t6 m0 waits", 32'(m0_gnt), 32'd0);
        step();
        drv(1, 0, 0, 2'b00, 9'h0, 32'h0); #2;
        chk("t6 m0 next", 32'(m0_gnt), 32'd1);
        step();
        drv(0, 0, 0, 2'b00, 9'h0, 32'h0);
        chk("t6 rvalid", 32'(m0_rvalid), 32'd1);
        chk("t6 rdata", m0_rdata, 32'h000000AB);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
